// File: rtl/isp_pattern_src_pkg.sv
// Shared definitions for the ISP test-pattern source.
// Pattern encodings, RGB565 bar colours and FSM states.
package isp_pattern_src_pkg;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_GRAD  = 2'd1;
    localparam logic [1:0] PAT_SOLID = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    localparam logic [15:0] COL_WHITE   = 16'hFFFF;
    localparam logic [15:0] COL_YELLOW  = 16'hFFE0;
    localparam logic [15:0] COL_CYAN    = 16'h07FF;
    localparam logic [15:0] COL_GREEN   = 16'h07E0;
    localparam logic [15:0] COL_MAGENTA = 16'hF81F;
    localparam logic [15:0] COL_RED     = 16'hF800;
    localparam logic [15:0] COL_BLUE    = 16'h001F;
    localparam logic [15:0] COL_BLACK   = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VBLANK
    } state_e;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        c = COL_BLACK;
        unique case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/isp_pattern_src_if.sv
// ISP pixel interface: 16-bit RGB565 pixel with valid strobe,
// start-of-frame and end-of-line markers; no backpressure.
interface isp_pattern_src_if;

    logic [15:0] Dout;
    logic        outEn;
    logic        sof;
    logic        eol;

    modport master (
        output Dout,
        output outEn,
        output sof,
        output eol
    );

    modport slave (
        input Dout,
        input outEn,
        input sof,
        input eol
    );

endinterface

// File: rtl/isp_pattern_color.sv
// Registered pattern generator: maps the timing counters of the
// current cycle to one RGB565 pixel, zero outside active video.
module isp_pattern_color
    import isp_pattern_src_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [1:0]  i_mode,
    input  logic [4:0]  i_hcnt,
    input  logic [5:0]  i_vcnt,
    input  logic [2:0]  i_bar,
    input  logic [4:0]  i_frame_cnt,
    input  logic [15:0] i_solid,
    output logic [15:0] o_pixel
);

    logic [15:0] w_pixel;
    logic [15:0] r_pixel;

    // Select the pattern value; blanking forces black.
    always_comb begin
        w_pixel = '0;
        if (i_valid) begin
            unique case (i_mode)
                PAT_BARS:  w_pixel = bar_color(i_bar);
                PAT_GRAD:  w_pixel = {i_hcnt, i_vcnt, i_frame_cnt};
                PAT_SOLID: w_pixel = i_solid;
                PAT_CHECK: w_pixel = (i_hcnt[4] ^ i_vcnt[4]) ?
                                     16'hFFFF : 16'h0000;
                default:   w_pixel = '0;
            endcase
        end
    end

    // Register the pixel so it lines up with the valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pixel <= '0;
        else     r_pixel <= w_pixel;
    end

    assign o_pixel = r_pixel;

endmodule

// File: rtl/isp_pattern_src.sv
// Frame-timed RGB565 test-pattern source for the ISP pixel path.
// Timing FSM and counters live here; pixel colour in a submodule.
module isp_pattern_src
    import isp_pattern_src_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [1:0]                mode,
    input  logic [15:0]               solid_color,
    output logic                      busy,
    isp_pattern_src_if.master         px
);

    localparam int LINE   = H_ACTIVE + H_BLANK;
    localparam int VB_CYC = V_BLANK * LINE;
    localparam int BAR_W  = H_ACTIVE / 8;

    // hcnt/vcnt are at least as wide as their gradient fields.
    localparam int HW  = max_i($clog2(H_ACTIVE) + 1, 5);
    localparam int VW  = max_i($clog2(V_ACTIVE) + 1, 6);
    localparam int BCW = $clog2(H_BLANK) + 1;
    localparam int VBW = $clog2(VB_CYC) + 1;
    localparam int BWW = $clog2(BAR_W) + 1;

    localparam logic [HW-1:0]  H_LAST   = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0]  V_LAST   = VW'(V_ACTIVE - 1);
    localparam logic [BCW-1:0] HB_LAST  = BCW'(H_BLANK - 1);
    localparam logic [VBW-1:0] VB_LAST  = VBW'(VB_CYC - 1);
    localparam logic [BWW-1:0] BAR_LAST = BWW'(BAR_W - 1);

    state_e         r_state;
    state_e         w_state_nxt;

    logic [HW-1:0]  r_hcnt;
    logic [BCW-1:0] r_hbcnt;
    logic [VBW-1:0] r_vbcnt;
    logic [VW-1:0]  r_vcnt;
    logic [BWW-1:0] r_barcnt;
    logic [2:0]     r_bar;
    logic [7:0]     r_frame_cnt;
    logic [1:0]     r_mode;
    logic [15:0]    r_solid;
    logic           r_stop_pend;
    logic           r_outEn;
    logic           r_sof;
    logic           r_eol;

    logic           w_active;
    logic           w_line_end;
    logic           w_hb_end;
    logic           w_vb_end;
    logic           w_last_line;
    logic           w_go;
    logic           w_reload;
    logic           w_bar_end;
    logic [15:0]    w_pixel;

    assign w_active    = (r_state == ST_ACTIVE);
    assign w_line_end  = w_active && (r_hcnt == H_LAST);
    assign w_hb_end    = (r_state == ST_HBLANK) && (r_hbcnt == HB_LAST);
    assign w_vb_end    = (r_state == ST_VBLANK) && (r_vbcnt == VB_LAST);
    assign w_last_line = (r_vcnt == V_LAST);
    assign w_go        = (r_state == ST_IDLE) && start;
    assign w_reload    = w_vb_end && !r_stop_pend;
    assign w_bar_end   = (r_barcnt == BAR_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic for active/blanking sequencing.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_line_end) w_state_nxt = ST_HBLANK;
            ST_HBLANK: if (w_hb_end)
                           w_state_nxt = w_last_line ? ST_VBLANK
                                                     : ST_ACTIVE;
            ST_VBLANK: if (w_vb_end)
                           w_state_nxt = r_stop_pend ? ST_IDLE
                                                     : ST_ACTIVE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Horizontal, blanking and vertical counters; all reload to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt  <= '0;
            r_hbcnt <= '0;
            r_vbcnt <= '0;
            r_vcnt  <= '0;
        end else begin
            r_hcnt  <= (w_active && !w_line_end) ?
                       r_hcnt + HW'(1) : '0;
            r_hbcnt <= (r_state == ST_HBLANK && !w_hb_end) ?
                       r_hbcnt + BCW'(1) : '0;
            r_vbcnt <= (r_state == ST_VBLANK && !w_vb_end) ?
                       r_vbcnt + VBW'(1) : '0;
            if (w_go || w_vb_end)
                r_vcnt <= '0;
            else if (w_hb_end && !w_last_line)
                r_vcnt <= r_vcnt + VW'(1);
        end
    end

    // Bar index advances every H_ACTIVE/8 pixels within a line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_barcnt <= '0;
            r_bar    <= '0;
        end else if (w_active && !w_line_end) begin
            if (w_bar_end) begin
                r_barcnt <= '0;
                r_bar    <= r_bar + 3'd1;
            end else begin
                r_barcnt <= r_barcnt + BWW'(1);
            end
        end else begin
            r_barcnt <= '0;
            r_bar    <= '0;
        end
    end

    // Frame counter and per-frame latching of pattern settings.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_mode      <= PAT_BARS;
            r_solid     <= '0;
        end else begin
            if (w_reload)
                r_frame_cnt <= r_frame_cnt + 8'd1;
            if (w_go || w_reload) begin
                r_mode  <= mode;
                r_solid <= solid_color;
            end
        end
    end

    // Sticky stop request, honoured at the end of the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stop_pend <= 1'b0;
        else if (w_vb_end && r_stop_pend)
            r_stop_pend <= 1'b0;
        else if (r_state != ST_IDLE && stop)
            r_stop_pend <= 1'b1;
    end

    // Strobes registered in step with the pixel register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outEn <= 1'b0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
        end else begin
            r_outEn <= w_active;
            r_sof   <= w_active && (r_hcnt == '0) && (r_vcnt == '0);
            r_eol   <= w_line_end;
        end
    end

    isp_pattern_color u_color (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (w_active),
        .i_mode      (r_mode),
        .i_hcnt      (r_hcnt[4:0]),
        .i_vcnt      (r_vcnt[5:0]),
        .i_bar       (r_bar),
        .i_frame_cnt (r_frame_cnt[4:0]),
        .i_solid     (r_solid),
        .o_pixel     (w_pixel)
    );

    assign px.Dout  = w_pixel;
    assign px.outEn = r_outEn;
    assign px.sof   = r_sof;
    assign px.eol   = r_eol;
    assign busy     = (r_state != ST_IDLE);

endmodule
